// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : Bundles the pipeline-side request/response signals and the
//           data-memory handshake of the MEM-stage load/store engine.
// Modports:
//   slave  - the load/store engine (mem_access_unit) view
//   master - the environment view (EX/MEM register, MEM/WB register, memory)
// Signals :
//   READ_WRITE[3:0]    op code from EX/MEM
//   ADDRESS[31:0]      byte address from EX/MEM
//   WRITE_DATA[31:0]   store source from EX/MEM
//   LOAD_DATA[31:0]    extended load result toward MEM/WB
//   BUSYWAIT           pipeline stall request
//   MISALIGNED         one-cycle pulse, misaligned access suppressed
//   BUS_ERROR          one-cycle pulse, access aborted on timeout
//   MEM_ADDRESS[31:0]  word-aligned memory address
//   MEM_READ/MEM_WRITE memory strobes, held for the whole access
//   MEM_WRITEDATA[31:0] lane-replicated store data
//   MEM_BYTE_EN[3:0]   byte lane enables
//   MEM_READDATA[31:0] word returned by memory
//   MEM_BUSYWAIT       memory not ready
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
  logic [3:0]  READ_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] LOAD_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;
  logic        BUS_ERROR;
  logic [31:0] MEM_ADDRESS;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_BUSYWAIT,
    output LOAD_DATA, BUSYWAIT, MISALIGNED, BUS_ERROR,
           MEM_ADDRESS, MEM_READ, MEM_WRITE, MEM_WRITEDATA, MEM_BYTE_EN
  );

  modport master (
    output READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_BUSYWAIT,
    input  LOAD_DATA, BUSYWAIT, MISALIGNED, BUS_ERROR,
           MEM_ADDRESS, MEM_READ, MEM_WRITE, MEM_WRITEDATA, MEM_BYTE_EN
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Purpose : MEM-stage load/store engine. Decodes READ_WRITE, runs a
//           word-wide data-memory handshake, replicates store data across
//           byte lanes, extracts and extends load data, and stalls the
//           pipeline (BUSYWAIT) while an access is outstanding.
// Parameters:
//   TIMEOUT_CYCLES - ACCESS cycles with MEM_BUSYWAIT=1 before abort
//   TIMEOUT_W      - width of the timeout counter
// Ports:
//   CLK   - clock, all state updates on posedge
//   RESET - asynchronous active-low reset
//   bus   - mem_access_unit_if.slave (pipeline side + memory side)
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_access_unit_if.slave   bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACCESS   = 2'd1;
  localparam logic [1:0] S_COMPLETE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Counter value at which one more busy cycle means the access has waited
  // TIMEOUT_CYCLES cycles.
  localparam logic [TIMEOUT_W-1:0] LP_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           r_state;
  logic [TIMEOUT_W-1:0] r_count;
  logic [31:0]          r_load_data;
  logic                 r_misaligned;
  logic                 r_bus_error;
  logic [31:0]          r_mem_address;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [31:0]          r_mem_writedata;
  logic [3:0]           r_mem_byte_en;
  logic                 r_is_load;
  logic                 r_unsigned;
  logic [1:0]           r_size;
  logic [1:0]           r_offset;

  logic        w_valid;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_unsigned;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_start;
  logic [3:0]  w_byte_en;
  logic [31:0] w_writedata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_value;

  // Op decode. Unlisted codes fall to the default and behave like 0000.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_valid    = 1'b0;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_unsigned = 1'b0;
    w_size     = SZ_BYTE;
    case (bus.READ_WRITE)
      4'b1000: begin w_valid = 1'b1; w_is_load = 1'b1; w_size = SZ_BYTE; end
      4'b1001: begin w_valid = 1'b1; w_is_load = 1'b1; w_size = SZ_HALF; end
      4'b1010: begin w_valid = 1'b1; w_is_load = 1'b1; w_size = SZ_WORD; end
      4'b1100: begin w_valid = 1'b1; w_is_load = 1'b1; w_size = SZ_BYTE; w_unsigned = 1'b1; end
      4'b1101: begin w_valid = 1'b1; w_is_load = 1'b1; w_size = SZ_HALF; w_unsigned = 1'b1; end
      4'b0100: begin w_valid = 1'b1; w_is_store = 1'b1; w_size = SZ_BYTE; end
      4'b0101: begin w_valid = 1'b1; w_is_store = 1'b1; w_size = SZ_HALF; end
      4'b0110: begin w_valid = 1'b1; w_is_store = 1'b1; w_size = SZ_WORD; end
      default: ;
    endcase
  end

  assign w_misaligned = w_valid &&
                        (((w_size == SZ_HALF) && bus.ADDRESS[0]) ||
                         ((w_size == SZ_WORD) && (bus.ADDRESS[1:0] != 2'b00)));
  assign w_start      = w_valid && !w_misaligned;

  // Lane enables and store data replication; loads share the same enables.
  always_comb begin
    w_byte_en   = 4'b1111;
    w_writedata = bus.WRITE_DATA;
    case (w_size)
      SZ_BYTE: begin
        w_byte_en   = 4'b0001 << bus.ADDRESS[1:0];
        w_writedata = {4{bus.WRITE_DATA[7:0]}};
      end
      SZ_HALF: begin
        w_byte_en   = bus.ADDRESS[1] ? 4'b1100 : 4'b0011;
        w_writedata = {2{bus.WRITE_DATA[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the offset/size latched at ACCESS entry, so input
  // changes during the access cannot disturb the result.
  always_comb begin
    case (r_offset)
      2'd0:    w_byte = bus.MEM_READDATA[7:0];
      2'd1:    w_byte = bus.MEM_READDATA[15:8];
      2'd2:    w_byte = bus.MEM_READDATA[23:16];
      default: w_byte = bus.MEM_READDATA[31:24];
    endcase
    w_half = r_offset[1] ? bus.MEM_READDATA[31:16] : bus.MEM_READDATA[15:0];
    case (r_size)
      SZ_BYTE: w_load_value = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load_value = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_value = bus.MEM_READDATA;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      r_load_data     <= '0;
      r_misaligned    <= 1'b0;
      r_bus_error     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_writedata <= '0;
      r_mem_byte_en   <= '0;
      r_is_load       <= 1'b0;
      r_unsigned      <= 1'b0;
      r_size          <= SZ_BYTE;
      r_offset        <= 2'd0;
    end else begin
      // Flags are single-cycle pulses unless re-asserted below.
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state         <= S_ACCESS;
            r_count         <= '0;
            r_mem_address   <= {bus.ADDRESS[31:2], 2'b00};
            r_mem_read      <= w_is_load;
            r_mem_write     <= w_is_store;
            r_mem_writedata <= w_is_store ? w_writedata : 32'h0;
            r_mem_byte_en   <= w_byte_en;
            r_is_load       <= w_is_load;
            r_unsigned      <= w_unsigned;
            r_size          <= w_size;
            r_offset        <= bus.ADDRESS[1:0];
          end else if (w_misaligned) begin
            r_misaligned <= 1'b1;
            r_load_data  <= '0;
          end
        end
        S_ACCESS: begin
          if (!bus.MEM_BUSYWAIT || (r_count == LP_LAST)) begin
            // Either outcome releases the memory and moves to COMPLETE.
            r_state         <= S_COMPLETE;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_mem_byte_en   <= '0;
            if (!bus.MEM_BUSYWAIT) begin
              if (r_is_load) r_load_data <= w_load_value;
            end else begin
              r_load_data <= '0;
              r_bus_error <= 1'b1;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        // COMPLETE lasts one cycle; the held instruction is not relaunched
        // because the pipeline advances at this same edge.
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The stall request is gated by RESET so it drops immediately on an
  // asynchronous reset even if a valid op is still presented.
  assign bus.BUSYWAIT      = RESET && ((r_state == S_ACCESS) ||
                                       ((r_state == S_IDLE) && w_start));
  assign bus.LOAD_DATA     = r_load_data;
  assign bus.MISALIGNED    = r_misaligned;
  assign bus.BUS_ERROR     = r_bus_error;
  assign bus.MEM_ADDRESS   = r_mem_address;
  assign bus.MEM_READ      = r_mem_read;
  assign bus.MEM_WRITE     = r_mem_write;
  assign bus.MEM_WRITEDATA = r_mem_writedata;
  assign bus.MEM_BYTE_EN   = r_mem_byte_en;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Purpose : Scoreboard bench for mem_access_unit. The stimulus process pushes
//           the expected outcome of every issued op into a queue; a monitor
//           pops and compares whenever the DUT completes an access or
//           reports a misaligned op. A small memory responder holds
//           MEM_BUSYWAIT high for a chosen number of ACCESS cycles.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int T = 4;  // timeout used for this bench

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(8)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic        misaligned;
    logic        timeout;
    logic        is_load;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    int          stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int          cur_wait  = 0;
  logic [31:0] cur_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: derives the outcome from access size, byte offset and
  // the number of busy cycles the memory will insert.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int k);
    exp_t e;
    int size, off;
    bit sgn;
    longint v;
    size = 0; sgn = 0;
    e.is_load = 1'b0;
    case (op)
      4'b1000: begin size = 1; sgn = 1; e.is_load = 1'b1; end
      4'b1001: begin size = 2; sgn = 1; e.is_load = 1'b1; end
      4'b1010: begin size = 4;          e.is_load = 1'b1; end
      4'b1100: begin size = 1;          e.is_load = 1'b1; end
      4'b1101: begin size = 2;          e.is_load = 1'b1; end
      4'b0100: size = 1;
      4'b0101: size = 2;
      4'b0110: size = 4;
      default: size = 0;
    endcase
    off          = int'(addr[1:0]);
    e.misaligned = (size != 0) && ((off % size) != 0);
    e.addr       = addr - 32'(off);
    e.be         = '0;
    e.wdata      = '0;
    for (int i = 0; i < 4; i++) begin
      e.be[i] = (i >= off) && (i < off + size);
      if (size != 0) e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    end
    v = 0;
    for (int b = 0; b < size; b++) v += longint'(rdata[8*((off + b) % 4) +: 8]) << (8*b);
    if (sgn && (v >= (longint'(1) << (8*size - 1)))) v -= (longint'(1) << (8*size));
    e.ldata   = v[31:0];
    e.timeout = !e.misaligned && (k >= T);
    if (e.misaligned) begin
      e.ldata = '0;
      e.stall = 0;
    end else if (e.timeout) begin
      e.ldata = '0;
      e.stall = 1 + T;
    end else begin
      e.stall = 2 + k;
    end
    return e;
  endfunction

  // Memory responder: busy for the first cur_wait ACCESS cycles.
  initial begin
    int acc_n;
    acc_n = 0;
    bus_if.MEM_BUSYWAIT = 1'b0;
    bus_if.MEM_READDATA = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.MEM_READDATA = cur_rdata;
      if (bus_if.MEM_READ || bus_if.MEM_WRITE) begin
        bus_if.MEM_BUSYWAIT = (acc_n < cur_wait);
        acc_n++;
      end else begin
        bus_if.MEM_BUSYWAIT = 1'b0;
        acc_n = 0;
      end
    end
  end

  // Monitor: observes the DUT and checks against the scoreboard.
  initial begin
    int          stall_cnt;
    bit          seen, stable, cap_rd, cap_wr;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    exp_t        e;
    stall_cnt = 0; seen = 0; stable = 1; cap_rd = 0; cap_wr = 0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0; seen = 0; stable = 1;
      end else begin
        if (bus_if.BUSYWAIT) begin
          stall_cnt++;
          if (bus_if.MEM_READ || bus_if.MEM_WRITE) begin
            if (!seen) begin
              seen = 1; cap_rd = bus_if.MEM_READ; cap_wr = bus_if.MEM_WRITE;
              cap_addr = bus_if.MEM_ADDRESS; cap_be = bus_if.MEM_BYTE_EN;
              cap_wdata = bus_if.MEM_WRITEDATA;
            end else if (bus_if.MEM_ADDRESS !== cap_addr || bus_if.MEM_BYTE_EN !== cap_be ||
                         bus_if.MEM_WRITEDATA !== cap_wdata ||
                         bus_if.MEM_READ !== cap_rd || bus_if.MEM_WRITE !== cap_wr) begin
              stable = 0;
            end
          end
        end else if (stall_cnt > 0) begin
          check("sb_has_access", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("acc_not_misaligned", 32'(e.misaligned), 32'd0);
            check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            check("bus_error", 32'(bus_if.BUS_ERROR), 32'(e.timeout));
            check("mem_read", 32'(cap_rd), 32'(e.is_load));
            check("mem_write", 32'(cap_wr), 32'(!e.is_load));
            check("mem_address", cap_addr, e.addr);
            check("byte_en", 32'(cap_be), 32'(e.be));
            if (!e.is_load) check("mem_writedata", cap_wdata, e.wdata);
            check("signals_stable", 32'(stable), 32'd1);
            check("strobes_low_in_complete", 32'(bus_if.MEM_READ | bus_if.MEM_WRITE), 32'd0);
            if (e.is_load || e.timeout) check("load_data", bus_if.LOAD_DATA, e.ldata);
          end
          stall_cnt = 0; seen = 0; stable = 1;
        end else if (bus_if.BUS_ERROR) begin
          check("stray_bus_error", 32'(bus_if.BUS_ERROR), 32'd0);
        end
        if (bus_if.MISALIGNED) begin
          check("sb_has_misaligned", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("misaligned_expected", 32'd1, 32'(e.misaligned));
            check("misaligned_load_data", bus_if.LOAD_DATA, 32'd0);
            check("misaligned_no_strobe", 32'(bus_if.MEM_READ | bus_if.MEM_WRITE), 32'd0);
          end
        end
      end
    end
  end

  // Issue one op (caller is just after a posedge) and hold it until the
  // pipeline would advance, i.e. a posedge preceded by BUSYWAIT=0.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int k);
    logic bw;
    int   n;
    sb_q.push_back(model(op, addr, wdata, rdata, k));
    cur_wait  = k;
    cur_rdata = rdata;
    bus_if.READ_WRITE = op;
    bus_if.ADDRESS    = addr;
    bus_if.WRITE_DATA = wdata;
    n = 0;
    do begin
      @(negedge clk);
      bw = bus_if.BUSYWAIT;
      @(posedge clk);
      n++;
    end while (bw && n < 40);
    if (bw) check("issue_timeout", 32'(n), 32'd0);
    #1;
    bus_if.READ_WRITE = 4'b0000;
  endtask

  task automatic idle(input int n);
    bus_if.READ_WRITE = 4'b0000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] OPS [8] = '{4'b1000, 4'b1001, 4'b1010, 4'b1100,
                                     4'b1101, 4'b0100, 4'b0101, 4'b0110};
  localparam logic [3:0] BAD [4] = '{4'b0111, 4'b1011, 4'b1111, 4'b0001};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus_if.READ_WRITE = 4'b1010;
    bus_if.ADDRESS    = 32'h0000_0100;
    bus_if.WRITE_DATA = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busywait", 32'(bus_if.BUSYWAIT), 32'd0);
    check("rst_load_data", bus_if.LOAD_DATA, 32'd0);
    check("rst_mem_read", 32'(bus_if.MEM_READ), 32'd0);
    check("rst_mem_write", 32'(bus_if.MEM_WRITE), 32'd0);
    check("rst_mem_address", bus_if.MEM_ADDRESS, 32'd0);
    check("rst_byte_en", 32'(bus_if.MEM_BYTE_EN), 32'd0);
    check("rst_writedata", bus_if.MEM_WRITEDATA, 32'd0);
    check("rst_flags", 32'({bus_if.MISALIGNED, bus_if.BUS_ERROR}), 32'd0);
    bus_if.READ_WRITE = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Directed cases from the block description.
    issue(4'b1000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2);
    check("lb_load_data", bus_if.LOAD_DATA, 32'hFFFF_FF80);
    issue(4'b1101, 32'h0000_0102, 32'h0, 32'h9ABC_5678, 0);
    check("lhu_load_data", bus_if.LOAD_DATA, 32'h0000_9ABC);
    issue(4'b1001, 32'h0000_0102, 32'h0, 32'h9ABC_5678, 1);
    check("lh_load_data", bus_if.LOAD_DATA, 32'hFFFF_9ABC);
    issue(4'b0100, 32'h0000_0201, 32'h1234_56AB, 32'h0, 1);
    issue(4'b0110, 32'h0000_0202, 32'h1111_2222, 32'h0, 0);
    idle(1);
    issue(4'b1010, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 50);
    check("timeout_load_data", bus_if.LOAD_DATA, 32'd0);
    idle(1);

    // Unlisted codes must not start an access or raise a flag.
    foreach (BAD[i]) begin
      bus_if.READ_WRITE = BAD[i];
      bus_if.ADDRESS    = 32'h0000_0401;
      @(negedge clk);
      check("bad_op_no_stall", 32'(bus_if.BUSYWAIT), 32'd0);
      @(posedge clk); #1;
      bus_if.READ_WRITE = 4'b0000;
      @(negedge clk);
      check("bad_op_no_effect",
            32'({bus_if.MEM_READ, bus_if.MEM_WRITE, bus_if.MISALIGNED}), 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the second ACCESS cycle of a long load.
    cur_wait = 50;
    bus_if.READ_WRITE = 4'b1010;
    bus_if.ADDRESS    = 32'h0000_0040;
    @(posedge clk);   // enter ACCESS
    @(posedge clk);   // ACCESS cycle 2
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_read", 32'(bus_if.MEM_READ), 32'd0);
    check("midrst_busywait", 32'(bus_if.BUSYWAIT), 32'd0);
    check("midrst_flags", 32'({bus_if.MISALIGNED, bus_if.BUS_ERROR}), 32'd0);
    bus_if.READ_WRITE = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    issue(4'b1010, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1);
    check("post_reset_lw", bus_if.LOAD_DATA, 32'hCAFE_F00D);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [31:0] addr, wd, rd;
      op   = OPS[$urandom_range(0, 7)];
      addr = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      issue(op, addr, wd, rd, $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
